// File: rtl/mul_div_unit.sv
// Execute-stage multiply/divide unit owning the HI/LO registers.
// One op in flight; results are held until the writeback path takes them, and HI/LO commit at that handshake.
module mul_div_unit #(
    parameter int TAG_W      = 6,
    parameter int MUL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       in_funct,
    input  logic [TAG_W-1:0] in_tag,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_reg_write,
    output logic [31:0]      out_data
);
    localparam logic [5:0] F_MADD  = 6'h00;
    localparam logic [5:0] F_MADDU = 6'h01;
    localparam logic [5:0] F_MUL   = 6'h02;
    localparam logic [5:0] F_MSUB  = 6'h04;
    localparam logic [5:0] F_MSUBU = 6'h05;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_CLZ   = 6'h20;
    localparam logic [5:0] F_CLO   = 6'h21;

    localparam int CNT_W = 8;

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         funct_q, funct_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        rem_q, rem_d;
    logic               neg_q_q, neg_q_d;
    logic               neg_r_q, neg_r_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic               rw_q, rw_d;
    logic [31:0]        data_q, data_d;
    logic [31:0]        hi_q, hi_d, lo_q, lo_d;
    logic [31:0]        hi_pend_q, hi_pend_d, lo_pend_q, lo_pend_d;
    logic               hilo_wr_q, hilo_wr_d;

    function automatic logic is_mul(input logic [5:0] f);
        return (f == F_MULT) || (f == F_MULTU) || (f == F_MUL) || (f == F_MADD) ||
               (f == F_MADDU) || (f == F_MSUB) || (f == F_MSUBU);
    endfunction

    function automatic logic [31:0] clz32(input logic [31:0] v);
        logic [31:0] n;
        logic        hit;
        n   = 32'd0;
        hit = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!hit) begin
                if (v[i]) hit = 1'b1;
                else      n   = n + 32'd1;
            end
        end
        return n;
    endfunction

    // Multiply operands come straight from the inputs when finishing on the accept cycle.
    logic [31:0] mul_a, mul_b;
    logic [5:0]  mul_f;
    logic        mul_signed, mul_fin;
    logic [63:0] ext_a, ext_b, prod, acc;

    always_comb begin
        mul_a      = (state_q == S_IDLE) ? in_a : a_q;
        mul_b      = (state_q == S_IDLE) ? in_b : b_q;
        mul_f      = (state_q == S_IDLE) ? in_funct : funct_q;
        mul_signed = (mul_f == F_MULT) || (mul_f == F_MUL) || (mul_f == F_MADD) || (mul_f == F_MSUB);
        ext_a      = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
        ext_b      = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
        prod       = ext_a * ext_b;
        case (mul_f)
            F_MADD, F_MADDU: acc = {hi_q, lo_q} + prod;
            F_MSUB, F_MSUBU: acc = {hi_q, lo_q} - prod;
            default:         acc = prod;
        endcase
    end

    // One restoring step: a_q shifts the dividend out and the quotient in.
    logic [32:0] div_shift, div_trial;
    assign div_shift = {rem_q, a_q[31]};
    assign div_trial = div_shift - {1'b0, b_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        funct_d   = funct_q;
        a_d       = a_q;
        b_d       = b_q;
        rem_d     = rem_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        tag_d     = tag_q;
        rw_d      = rw_q;
        data_d    = data_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        hi_pend_d = hi_pend_q;
        lo_pend_d = lo_pend_q;
        hilo_wr_d = hilo_wr_q;
        mul_fin   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    funct_d   = in_funct;
                    tag_d     = in_tag;
                    a_d       = in_a;
                    b_d       = in_b;
                    cnt_d     = '0;
                    rw_d      = 1'b0;
                    data_d    = 32'd0;
                    hilo_wr_d = 1'b0;
                    if (is_mul(in_funct)) begin
                        if (MUL_CYCLES == 1) mul_fin = 1'b1;
                        else                 state_d = S_MUL;
                    end else begin
                        case (in_funct)
                            F_DIV, F_DIVU: begin
                                if (in_b == 32'd0) begin
                                    hilo_wr_d = 1'b1;
                                    hi_pend_d = in_a;
                                    lo_pend_d = 32'hFFFF_FFFF;
                                    state_d   = S_DONE;
                                end else begin
                                    neg_r_d = (in_funct == F_DIV) && in_a[31];
                                    neg_q_d = (in_funct == F_DIV) && (in_a[31] ^ in_b[31]);
                                    a_d     = ((in_funct == F_DIV) && in_a[31]) ? -in_a : in_a;
                                    b_d     = ((in_funct == F_DIV) && in_b[31]) ? -in_b : in_b;
                                    rem_d   = 32'd0;
                                    state_d = S_DIV;
                                end
                            end
                            F_MFHI: begin rw_d = 1'b1; data_d = hi_q; state_d = S_DONE; end
                            F_MFLO: begin rw_d = 1'b1; data_d = lo_q; state_d = S_DONE; end
                            F_MTHI: begin
                                hilo_wr_d = 1'b1; hi_pend_d = in_a; lo_pend_d = lo_q; state_d = S_DONE;
                            end
                            F_MTLO: begin
                                hilo_wr_d = 1'b1; hi_pend_d = hi_q; lo_pend_d = in_a; state_d = S_DONE;
                            end
                            F_CLZ: begin rw_d = 1'b1; data_d = clz32(in_a); state_d = S_DONE; end
                            F_CLO: begin rw_d = 1'b1; data_d = clz32(~in_a); state_d = S_DONE; end
                            default: state_d = S_DONE;
                        endcase
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == CNT_W'(MUL_CYCLES - 2)) mul_fin = 1'b1;
                else                                 cnt_d = cnt_q + CNT_W'(1);
            end
            S_DIV: begin
                a_d   = {a_q[30:0], ~div_trial[32]};
                rem_d = div_trial[32] ? div_shift[31:0] : div_trial[31:0];
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(31)) state_d = S_FIX;
            end
            S_FIX: begin
                hilo_wr_d = 1'b1;
                hi_pend_d = neg_r_q ? -rem_q : rem_q;
                lo_pend_d = neg_q_q ? -a_q : a_q;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    if (hilo_wr_q) begin
                        hi_d = hi_pend_q;
                        lo_d = lo_pend_q;
                    end
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (mul_fin) begin
            state_d = S_DONE;
            if (mul_f == F_MUL) begin
                rw_d   = 1'b1;
                data_d = prod[31:0];
            end else begin
                hilo_wr_d              = 1'b1;
                {hi_pend_d, lo_pend_d} = acc;
            end
        end

        // Flush beats a same-cycle handshake: nothing commits.
        if (flush) begin
            state_d = S_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            funct_q   <= 6'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            rem_q     <= 32'd0;
            neg_q_q   <= 1'b0;
            neg_r_q   <= 1'b0;
            tag_q     <= '0;
            rw_q      <= 1'b0;
            data_q    <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            hi_pend_q <= 32'd0;
            lo_pend_q <= 32'd0;
            hilo_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            funct_q   <= funct_d;
            a_q       <= a_d;
            b_q       <= b_d;
            rem_q     <= rem_d;
            neg_q_q   <= neg_q_d;
            neg_r_q   <= neg_r_d;
            tag_q     <= tag_d;
            rw_q      <= rw_d;
            data_q    <= data_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_pend_q <= hi_pend_d;
            lo_pend_q <= lo_pend_d;
            hilo_wr_q <= hilo_wr_d;
        end
    end

    assign in_ready      = (state_q == S_IDLE);
    assign out_valid     = (state_q == S_DONE);
    assign out_tag       = tag_q;
    assign out_reg_write = rw_q;
    assign out_data      = data_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corner cases plus randomized ops against an arithmetic HI/LO model.
module tb_mul_div_unit;
    localparam int TAG_W      = 6;
    localparam int MUL_CYCLES = 3;

    localparam logic [5:0] F_MADD  = 6'h00, F_MADDU = 6'h01, F_MUL  = 6'h02;
    localparam logic [5:0] F_MSUB  = 6'h04, F_MSUBU = 6'h05;
    localparam logic [5:0] F_MFHI  = 6'h10, F_MTHI  = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18, F_MULTU = 6'h19, F_DIV  = 6'h1A, F_DIVU = 6'h1B;
    localparam logic [5:0] F_CLZ   = 6'h20, F_CLO   = 6'h21;

    logic             clk = 1'b0;
    logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_reg_write;
    logic [5:0]       in_funct;
    logic [TAG_W-1:0] in_tag, out_tag;
    logic [31:0]      in_a, in_b, out_data;

    mul_div_unit #(.TAG_W(TAG_W), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_funct(in_funct), .in_tag(in_tag),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
        .out_reg_write(out_reg_write), .out_data(out_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic             rw;
        logic [31:0]      data;
    } exp_t;

    exp_t             expq[$];
    int               errors = 0;
    int               checks = 0;
    logic [31:0]      hi_m, lo_m;
    logic [TAG_W-1:0] tag_ctr;
    bit               rand_bp = 1'b0;
    logic             ready_force = 1'b1;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic int lead(input logic [31:0] v, input logic bitval);
        int n = 0;
        for (int i = 31; i >= 0 && v[i] == bitval; i--) n++;
        return n;
    endfunction

    // Architectural model: what HI/LO and the GPR result should be after this op commits.
    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic rw, output logic [31:0] d);
        longint          ps;
        longint unsigned pu;
        logic [63:0]     hl;
        int              q, r;
        rw = 1'b0;
        d  = 32'd0;
        hl = {hi_m, lo_m};
        ps = longint'(int'($signed(a))) * longint'(int'($signed(b)));
        pu = 64'(a) * 64'(b);
        case (f)
            F_MULT:  hl = ps;
            F_MULTU: hl = pu;
            F_MUL:   begin rw = 1'b1; d = ps[31:0]; end
            F_MADD:  hl = hl + ps;
            F_MADDU: hl = hl + pu;
            F_MSUB:  hl = hl - ps;
            F_MSUBU: hl = hl - pu;
            F_DIV: begin
                if (b == 0) hl = {a, 32'hFFFF_FFFF};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) hl = {32'd0, 32'h8000_0000};
                else begin
                    q  = $signed(a) / $signed(b);
                    r  = $signed(a) % $signed(b);
                    hl = {r, q};
                end
            end
            F_DIVU: begin
                if (b == 0) hl = {a, 32'hFFFF_FFFF};
                else        hl = {a % b, a / b};
            end
            F_MFHI: begin rw = 1'b1; d = hi_m; end
            F_MFLO: begin rw = 1'b1; d = lo_m; end
            F_MTHI: hl[63:32] = a;
            F_MTLO: hl[31:0]  = a;
            F_CLZ:  begin rw = 1'b1; d = 32'(lead(a, 1'b0)); end
            F_CLO:  begin rw = 1'b1; d = 32'(lead(a, 1'b1)); end
            default: ;
        endcase
        {hi_m, lo_m} = hl;
    endfunction

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_bp ? ($urandom_range(0, 3) != 0) : ready_force;
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready && !flush) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: got tag %0h data %0h, expected no result", out_tag, out_data);
            end else begin
                exp_t e;
                e = expq.pop_front();
                check("result{tag,rw,data}", {25'd0, out_tag, out_reg_write, out_data}, {25'd0, e.tag, e.rw, e.data});
            end
        end
    end

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input bit wait_out, output int lat);
        exp_t e;
        int   w;
        lat = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_funct = f;
        in_tag   = tag_ctr;
        in_a     = a;
        in_b     = b;
        w = 0;
        while (!in_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
            lat = -1;
            return;
        end
        if (push) begin
            e.tag = tag_ctr;
            model(f, a, b, e.rw, e.data);
            expq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tag_ctr++;
        if (wait_out) begin
            do begin
                @(negedge clk);
                lat++;
            end while (!out_valid && lat < 100);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    logic [5:0] funcs [17] = '{F_MADD, F_MADDU, F_MUL, F_MSUB, F_MSUBU, F_MFHI, F_MTHI, F_MFLO,
                               F_MTLO, F_MULT, F_MULTU, F_DIV, F_DIVU, F_CLZ, F_CLO, 6'h3F, 6'h07};

    initial begin
        int          lat, w;
        logic [31:0] ra, rb, md;
        logic [5:0]  rf;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_funct = 6'd0; in_tag = '0;
        in_a = 32'd0; in_b = 32'd0; hi_m = 32'd0; lo_m = 32'd0; tag_ctr = 6'd1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_reg_write", 64'(out_reg_write), 64'd0);
        rst = 1'b0;

        issue(F_MULT, 32'hFFFF_FFFE, 32'd3, 1, 1, lat);
        check("mult_latency", 64'(lat), 64'(MUL_CYCLES));
        issue(F_MFHI, 0, 0, 1, 1, lat);
        issue(F_MFLO, 0, 0, 1, 1, lat);
        issue(F_MULTU, 32'hFFFF_FFFF, 32'd2, 1, 1, lat);
        check("multu_latency", 64'(lat), 64'(MUL_CYCLES));
        issue(F_MFHI, 0, 0, 1, 1, lat);
        issue(F_MFLO, 0, 0, 1, 1, lat);
        issue(F_MTHI, 32'd0, 0, 1, 1, lat);
        check("mthi_latency", 64'(lat), 64'd1);
        issue(F_MTLO, 32'hFFFF_FFFF, 0, 1, 1, lat);
        issue(F_MADD, 32'd1, 32'd1, 1, 1, lat);
        issue(F_MFHI, 0, 0, 1, 1, lat);
        issue(F_MFLO, 0, 0, 1, 1, lat);
        issue(F_MTHI, 32'd0, 0, 1, 1, lat);
        issue(F_MTLO, 32'd0, 0, 1, 1, lat);
        issue(F_MSUB, 32'd1, 32'd2, 1, 1, lat);
        issue(F_MFHI, 0, 0, 1, 1, lat);
        issue(F_MFLO, 0, 0, 1, 1, lat);
        issue(F_DIV, 32'hFFFF_FFF9, 32'd2, 1, 1, lat);
        check("div_latency", 64'(lat), 64'd34);
        issue(F_MFHI, 0, 0, 1, 1, lat);
        issue(F_MFLO, 0, 0, 1, 1, lat);
        issue(F_DIVU, 32'd7, 32'd0, 1, 1, lat);
        check("divu_by0_latency", 64'(lat), 64'd1);
        issue(F_MFHI, 0, 0, 1, 1, lat);
        issue(F_MFLO, 0, 0, 1, 1, lat);
        issue(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1, lat);
        check("div_ovf_latency", 64'(lat), 64'd34);
        issue(F_MFHI, 0, 0, 1, 1, lat);
        issue(F_MFLO, 0, 0, 1, 1, lat);
        issue(F_CLZ, 32'h0001_0000, 0, 1, 1, lat);
        check("clz_latency", 64'(lat), 64'd1);
        issue(F_CLO, 32'hFFFF_FFFF, 0, 1, 1, lat);
        issue(F_CLZ, 32'd0, 0, 1, 1, lat);
        issue(6'h3F, 32'h1234, 32'h5678, 1, 1, lat);
        check("unknown_latency", 64'(lat), 64'd1);
        issue(F_MUL, 32'hFFFF_FFF0, 32'h0001_2345, 1, 1, lat);
        issue(F_MFLO, 0, 0, 1, 1, lat);

        // Flush mid-divide: the in-flight result and its HI/LO update are dropped.
        issue(F_DIV, 32'd100, 32'd3, 0, 0, lat);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        check("flush_div_in_ready", 64'(in_ready), 64'd1);
        check("flush_div_out_valid", 64'(out_valid), 64'd0);
        issue(F_MFLO, 0, 0, 1, 1, lat);

        // Flush a held result in DONE.
        ready_force = 1'b0;
        @(posedge clk);
        issue(F_MTLO, 32'hDEAD_BEEF, 0, 0, 1, lat);
        check("flush_done_valid_before", 64'(out_valid), 64'd1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_done_valid_after", 64'(out_valid), 64'd0);
        ready_force = 1'b1;
        issue(F_MFLO, 0, 0, 1, 1, lat);

        // Backpressure: outputs held stable, pending HI/LO not committed until the handshake.
        ready_force = 1'b0;
        @(posedge clk);
        ra = 32'h0000_ABCD;
        rb = 32'h0001_0003;
        md = ra * rb;
        issue(F_MUL, ra, rb, 1, 1, lat);
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", 64'(out_valid), 64'd1);
            check("hold_data", 64'(out_data), 64'(md));
            check("hold_in_ready", 64'(in_ready), 64'd0);
            @(negedge clk);
        end
        ready_force = 1'b1;
        ready_force = 1'b0;
        @(posedge clk);
        ready_force = 1'b1;
        issue(F_MULTU, 32'h1234_5678, 32'h9ABC_DEF0, 1, 1, lat);
        issue(F_MFHI, 0, 0, 1, 1, lat);
        issue(F_MFLO, 0, 0, 1, 1, lat);

        rand_bp = 1'b1;
        for (int n = 0; n < 300; n++) begin
            rf = funcs[$urandom_range(0, 16)];
            case ($urandom_range(0, 7))
                0: ra = 32'h8000_0000;
                1: ra = $urandom_range(0, 20);
                2: ra = 32'hFFFF_FFFF - $urandom_range(0, 20);
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = $urandom_range(1, 9);
                default: rb = $urandom;
            endcase
            issue(rf, ra, rb, 1, 0, lat);
        end
        rand_bp = 1'b0;
        ready_force = 1'b1;
        w = 0;
        while (expq.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end

        // Async reset in the middle of a multiply.
        issue(F_MTHI, 32'h5A5A_5A5A, 0, 1, 1, lat);
        issue(F_MULT, 32'd9, 32'd9, 0, 0, lat);
        @(negedge clk);
        check("pre_rst_in_ready", 64'(in_ready), 64'd0);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_tag", 64'(out_tag), 64'd0);
        check("mid_rst_out_data", 64'(out_data), 64'd0);
        check("mid_rst_out_reg_write", 64'(out_reg_write), 64'd0);
        hi_m = 32'd0;
        lo_m = 32'd0;
        @(negedge clk);
        rst = 1'b0;
        issue(F_MFHI, 0, 0, 1, 1, lat);
        issue(F_MFLO, 0, 0, 1, 1, lat);

        w = 0;
        while (expq.size() > 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        check("scoreboard_drained", 64'(expq.size()), 64'd0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
